handshake_constant_seq: RTL and testbench
=========================================

Name: handshake_constant_seq

Overview:
- Elastic constant/sequence source for dataflow circuits: each token accepted on the ctrl channel produces exactly one data token on the outs channel.
- Generalises the plain handshake constant in three ways:
  - parametrised value and width;
  - an internal token buffer of NUM_SLOTS, which breaks the combinational ready/valid path;
  - an optional arithmetic-sequence mode, where each emitted token carries the previous value plus STEP.
- Sits wherever the datapath needs per-invocation constants, loop-index seeds or strided address bases.

Parameters:
- DATA_WIDTH, 32, width of outs in bits (>=1).
- CONST_VALUE, 1, first/constant value; truncated to DATA_WIDTH LSBs.
- NUM_SLOTS, 2, buffered token capacity (>=1).
- SEQ_MODE, 0, 0 = constant output, 1 = arithmetic sequence.
- STEP, 1, increment per emitted token in SEQ_MODE=1; truncated to DATA_WIDTH, two's complement.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ctrl_valid  input  1  control token present.
- ctrl_ready  output  1  block can accept a control token.
- outs  output  DATA_WIDTH  current output value.
- outs_valid  output  1  output token present.
- outs_ready  input  1  consumer accepts token.
- occupancy  output  $clog2(NUM_SLOTS+1)  tokens currently held.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- State: token counter cnt (0..NUM_SLOTS) and value register val. Both are reset asynchronously when rst=0.
- Reset values: cnt=0, val=CONST_VALUE[DATA_WIDTH-1:0], outs_valid=0, ctrl_ready=1, occupancy=0, outs=CONST_VALUE truncated.
- Handshake signals:
  - ctrl_ready = (cnt < NUM_SLOTS), decoded from register only; it never depends combinationally on outs_ready.
  - outs_valid = (cnt != 0).
  - outs = val at all times; val is stable while outs_valid=1 and outs_ready=0.
  - occupancy = cnt.
- Events:
  - push = ctrl_valid & ctrl_ready.
  - pop = outs_valid & outs_ready.
- Counter update:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop in the same cycle: cnt unchanged.
  - neither: unchanged.
- Full condition (cnt=NUM_SLOTS): ctrl_ready=0 even if a pop occurs that cycle (no bypass). ctrl_ready rises the cycle after the pop.
- Empty condition (cnt=0): outs_valid=0. A push into an empty buffer is visible on outs_valid the next cycle (latency 1; no combinational ctrl_valid-to-outs_valid path).
- Throughput:
  - NUM_SLOTS>=2: 1 token/cycle sustained.
  - NUM_SLOTS=1: 1 token per 2 cycles.
- Value update:
  - SEQ_MODE=0: val never changes.
  - SEQ_MODE=1: on each pop, val <= val + STEP modulo 2^DATA_WIDTH. Wrap-around is silent; no overflow flag.
  - The Nth emitted token (N from 0) carries CONST_VALUE + N*STEP mod 2^DATA_WIDTH.
  - Push has no effect on val.
- Reset mid-operation: all buffered tokens are discarded, val returns to CONST_VALUE, and outs_valid drops immediately (asynchronously). No token is emitted until a new push.
- Input validity: ctrl_valid that is deasserted without acceptance is legal (the block makes no retention assumption). outs_ready may toggle freely.
- Elaboration checks: an elaboration error is required for NUM_SLOTS<1 or DATA_WIDTH<1.

Test Plan:
- Reset and single token: release rst, then pulse ctrl_valid for 1 cycle with outs_ready=1. Required: ctrl_ready=1 at reset; outs_valid=1 with outs=1 exactly one cycle after the push; occupancy returns to 0.
- Back-pressure fill (NUM_SLOTS=2): outs_ready=0, ctrl_valid=1 held. Required: accepts 2 tokens, then ctrl_ready=0 and occupancy=2. Raise outs_ready: pops on consecutive cycles; ctrl_ready=1 the cycle after the first pop.
- Simultaneous push/pop at occupancy=1 with both ready: occupancy stays 1 across 10 cycles; 10 tokens are emitted.
- Sequence wrap (DATA_WIDTH=8, SEQ_MODE=1, CONST_VALUE=250, STEP=3): emit 4 tokens. Required: outs = 250, 253, 0, 3.
- Negative step (DATA_WIDTH=8, SEQ_MODE=1, CONST_VALUE=5, STEP=-2): outs = 5, 3, 1, 255. With outs_ready held 0 for 3 cycles, outs holds at 3.
- Mid-operation reset (occupancy=2, SEQ_MODE=1, val already advanced): assert rst asynchronously between clock edges. Required: outs_valid=0 and occupancy=0 immediately. After release, the next push yields outs=CONST_VALUE.

Source files
------------

// File: rtl/handshake_constant_seq_if.sv
// Handshake bundle for handshake_constant_seq: ctrl token channel in, data token channel out.
// A token moves on a channel in any cycle where its valid and ready are both 1 at the rising edge.
interface handshake_constant_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    input  ctrl_valid,
    output ctrl_ready,
    output outs,
    output outs_valid,
    input  outs_ready
  );

  modport slave (
    output ctrl_valid,
    input  ctrl_ready,
    input  outs,
    input  outs_valid,
    output outs_ready
  );
endinterface

// File: rtl/handshake_constant_seq.sv
// Elastic constant / arithmetic-sequence source: every accepted ctrl token yields one outs token,
// buffered up to NUM_SLOTS deep so ctrl_ready never depends combinationally on outs_ready.
module handshake_constant_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONST_VALUE = 1,
  parameter int NUM_SLOTS   = 2,
  parameter int SEQ_MODE    = 0,
  parameter int STEP        = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  handshake_constant_seq_if.master       bus,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy
);

  localparam int                    CW      = $clog2(NUM_SLOTS + 1);
  localparam logic [DATA_WIDTH-1:0] CONST_V = DATA_WIDTH'(CONST_VALUE);
  localparam logic [DATA_WIDTH-1:0] STEP_V  = DATA_WIDTH'(STEP);
  localparam logic [CW-1:0]         FULL_V  = CW'(NUM_SLOTS);
  localparam bit                    SEQ     = (SEQ_MODE != 0);

  generate
    if (NUM_SLOTS < 1) begin : g_bad_slots
      $error("handshake_constant_seq: NUM_SLOTS must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("handshake_constant_seq: DATA_WIDTH must be >= 1");
    end
  endgenerate

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  push, pop;

  // Handshake outputs decode registered state only, so no in-to-out combinational path exists.
  assign bus.ctrl_ready = (cnt_q < FULL_V);
  assign bus.outs_valid = (cnt_q != '0);
  assign bus.outs       = val_q;
  assign occupancy      = cnt_q;

  always_comb begin
    push  = bus.ctrl_valid & bus.ctrl_ready;
    pop   = bus.outs_valid & bus.outs_ready;
    cnt_d = cnt_q;
    val_d = val_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
    // Sequence advances on consumption only; wrap-around is silent.
    if (SEQ && pop) begin
      val_d = val_q + STEP_V;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      val_q <= CONST_V;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  end

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed bench: constant instance (defaults), wrapping sequence instance, negative-step instance.
module tb_handshake_constant_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   tokens;

  logic [1:0] occ0, occ1, occ2;

  handshake_constant_seq_if #(.DATA_WIDTH(32)) bus0 ();
  handshake_constant_seq_if #(.DATA_WIDTH(8))  bus1 ();
  handshake_constant_seq_if #(.DATA_WIDTH(8))  bus2 ();

  handshake_constant_seq u_const (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0),
    .occupancy (occ0)
  );

  handshake_constant_seq #(
    .DATA_WIDTH(8), .CONST_VALUE(250), .NUM_SLOTS(2), .SEQ_MODE(1), .STEP(3)
  ) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .occupancy (occ1)
  );

  handshake_constant_seq #(
    .DATA_WIDTH(8), .CONST_VALUE(5), .NUM_SLOTS(2), .SEQ_MODE(1), .STEP(-2)
  ) u_neg (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .occupancy (occ2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: inputs set before the call are sampled at the edge; outputs read 1ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    tokens = 0;
    rst    = 1'b0;
    bus0.ctrl_valid = 1'b0; bus0.outs_ready = 1'b0;
    bus1.ctrl_valid = 1'b0; bus1.outs_ready = 1'b0;
    bus2.ctrl_valid = 1'b0; bus2.outs_ready = 1'b0;

    // reset state
    #12;
    chk("rst_ctrl_ready", 32'(bus0.ctrl_ready), 32'd1);
    chk("rst_outs_valid", 32'(bus0.outs_valid), 32'd0);
    chk("rst_occupancy",  32'(occ0),            32'd0);
    chk("rst_outs",       bus0.outs,            32'd1);
    chk("rst_wrap_outs",  32'(bus1.outs),       32'd250);
    chk("rst_neg_outs",   32'(bus2.outs),       32'd5);
    rst = 1'b1;

    // single token, latency 1
    bus0.outs_ready = 1'b1;
    bus0.ctrl_valid = 1'b1;
    cyc();
    bus0.ctrl_valid = 1'b0;
    chk("single_valid", 32'(bus0.outs_valid), 32'd1);
    chk("single_outs",  bus0.outs,            32'd1);
    chk("single_occ",   32'(occ0),            32'd1);
    cyc();
    chk("single_drain_occ",   32'(occ0),            32'd0);
    chk("single_drain_valid", 32'(bus0.outs_valid), 32'd0);

    // back-pressure fill to full
    bus0.outs_ready = 1'b0;
    bus0.ctrl_valid = 1'b1;
    cyc();
    chk("fill1_occ",   32'(occ0),            32'd1);
    chk("fill1_ready", 32'(bus0.ctrl_ready), 32'd1);
    cyc();
    chk("full_occ",   32'(occ0),            32'd2);
    chk("full_ready", 32'(bus0.ctrl_ready), 32'd0);
    cyc();
    chk("full_hold_occ", 32'(occ0), 32'd2);

    // pop while full: no bypass, ready returns next cycle
    bus0.outs_ready = 1'b1;
    cyc();
    chk("after_pop_occ",   32'(occ0),            32'd1);
    chk("after_pop_ready", 32'(bus0.ctrl_ready), 32'd1);

    // simultaneous push/pop at occupancy 1
    for (int i = 0; i < 10; i++) begin
      if (bus0.outs_valid && bus0.outs_ready) tokens++;
      cyc();
      chk("steady_occ",  32'(occ0), 32'd1);
      chk("steady_outs", bus0.outs, 32'd1);
    end
    chk("steady_tokens", 32'(tokens), 32'd10);
    bus0.ctrl_valid = 1'b0;
    cyc();
    chk("steady_drain_occ", 32'(occ0), 32'd0);
    bus0.outs_ready = 1'b0;

    // sequence wrap: 250, 253, 0, 3
    bus1.ctrl_valid = 1'b1;
    bus1.outs_ready = 1'b1;
    cyc();
    chk("wrap_t0", 32'(bus1.outs), 32'd250);
    chk("wrap_t0_valid", 32'(bus1.outs_valid), 32'd1);
    cyc();
    chk("wrap_t1", 32'(bus1.outs), 32'd253);
    cyc();
    chk("wrap_t2", 32'(bus1.outs), 32'd0);
    cyc();
    chk("wrap_t3", 32'(bus1.outs), 32'd3);
    bus1.ctrl_valid = 1'b0;
    cyc();
    chk("wrap_drain_occ", 32'(occ1), 32'd0);
    chk("wrap_next_val",  32'(bus1.outs), 32'd6);
    bus1.outs_ready = 1'b0;

    // negative step: 5, 3 (held under back-pressure), 1, 255
    bus2.ctrl_valid = 1'b1;
    bus2.outs_ready = 1'b1;
    cyc();
    chk("neg_t0", 32'(bus2.outs), 32'd5);
    cyc();
    chk("neg_t1", 32'(bus2.outs), 32'd3);
    bus2.ctrl_valid = 1'b0;
    bus2.outs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("neg_hold_outs",  32'(bus2.outs),       32'd3);
      chk("neg_hold_valid", 32'(bus2.outs_valid), 32'd1);
    end
    bus2.ctrl_valid = 1'b1;
    bus2.outs_ready = 1'b1;
    cyc();
    chk("neg_t2", 32'(bus2.outs), 32'd1);
    cyc();
    chk("neg_t3", 32'(bus2.outs), 32'd255);
    bus2.ctrl_valid = 1'b0;
    cyc();
    chk("neg_drain_occ", 32'(occ2), 32'd0);
    bus2.outs_ready = 1'b0;

    // mid-operation asynchronous reset with advanced value and two tokens held
    bus1.ctrl_valid = 1'b1;
    cyc();
    cyc();
    bus1.ctrl_valid = 1'b0;
    chk("mid_occ_before", 32'(occ1),      32'd2);
    chk("mid_val_before", 32'(bus1.outs), 32'd6);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus1.outs_valid), 32'd0);
    chk("mid_rst_occ",   32'(occ1),            32'd0);
    chk("mid_rst_outs",  32'(bus1.outs),       32'd250);
    #2;
    rst = 1'b1;
    cyc();
    chk("mid_idle_valid", 32'(bus1.outs_valid), 32'd0);
    bus1.ctrl_valid = 1'b1;
    bus1.outs_ready = 1'b1;
    cyc();
    bus1.ctrl_valid = 1'b0;
    chk("mid_after_outs",  32'(bus1.outs),       32'd250);
    chk("mid_after_valid", 32'(bus1.outs_valid), 32'd1);
    cyc();
    chk("mid_after_occ", 32'(occ1), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
